// File: rtl/semaforo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : semaforo_pkg
// Description : Phase codes, lamp encodings and request indices shared by the
//               intersection phase scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package semaforo_pkg;

    typedef enum logic [2:0] {
        ALL_RED   = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        PED_WALK  = 3'd5,
        EMERG     = 3'd6
    } phase_e;

    typedef logic [2:0] light_t;

    localparam light_t LIGHT_R = 3'b100;
    localparam light_t LIGHT_Y = 3'b010;
    localparam light_t LIGHT_G = 3'b001;

    localparam logic [1:0] NS  = 2'd0;
    localparam logic [1:0] EW  = 2'd1;
    localparam logic [1:0] PED = 2'd2;

    function automatic light_t ns_light_of(input phase_e p);
        case (p)
            NS_GREEN:  return LIGHT_G;
            NS_YELLOW: return LIGHT_Y;
            default:   return LIGHT_R;
        endcase
    endfunction

    function automatic light_t ew_light_of(input phase_e p);
        case (p)
            EW_GREEN:  return LIGHT_G;
            EW_YELLOW: return LIGHT_Y;
            default:   return LIGHT_R;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/semaforo_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : semaforo_sched_if
// Description : Tick, request and lamp signals between the prescaler/sensors
//               side and the phase scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface semaforo_sched_if;
    import semaforo_pkg::*;

    logic   tick;
    logic   req_ns;
    logic   req_ew;
    logic   req_ped;
    logic   emerg;
    light_t ns_light;
    light_t ew_light;
    logic   walk;
    logic   ped_ack;
    logic [2:0] phase;

    modport master (
        output tick, req_ns, req_ew, req_ped, emerg,
        input  ns_light, ew_light, walk, ped_ack, phase
    );

    modport slave (
        input  tick, req_ns, req_ew, req_ped, emerg,
        output ns_light, ew_light, walk, ped_ack, phase
    );
endinterface
`default_nettype wire

// File: rtl/semaforo_sched_rr_arbiter3.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter3
// Description : Combinational three-way round-robin arbiter; search starts
//               just after the last served requester.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter3
    import semaforo_pkg::*;
(
    input  wire logic [2:0] pend,
    input  wire logic [1:0] last_served,
    output logic      [2:0] grant,
    output logic            valid
);

    logic [1:0] w_first;
    logic [1:0] w_second;
    logic [1:0] w_third;

    always_comb begin
        w_first  = NS;
        w_second = EW;
        w_third  = PED;
        case (last_served)
            NS: begin
                w_first  = EW;
                w_second = PED;
                w_third  = NS;
            end
            EW: begin
                w_first  = PED;
                w_second = NS;
                w_third  = EW;
            end
            default: ;
        endcase

        grant = 3'b000;
        if (pend[w_first])
            grant[w_first] = 1'b1;
        else if (pend[w_second])
            grant[w_second] = 1'b1;
        else if (pend[w_third])
            grant[w_third] = 1'b1;
    end

    assign valid = |pend;

endmodule
`default_nettype wire

// File: rtl/semaforo_sched.sv
`default_nettype none
// ============================================================================
// Module      : semaforo_sched
// Description : Tick-driven phase scheduler for a two-road intersection with a
//               pedestrian crossing and an emergency all-red override.
// Revision    : 1.0 - initial release
// ============================================================================
module semaforo_sched
    import semaforo_pkg::*;
#(
    parameter int GREEN_MIN = 5,
    parameter int GREEN_MAX = 15,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 1,
    parameter int WALK_T    = 8,
    parameter int CNT_W     = 5
) (
    input  wire logic        CLK100MHZ,
    input  wire logic        reset,
    semaforo_sched_if.slave  sig
);

    if (GREEN_MIN < 1 || GREEN_MIN > 2**CNT_W - 1 ||
        GREEN_MAX < 1 || GREEN_MAX > 2**CNT_W - 1 ||
        YELLOW_T  < 1 || YELLOW_T  > 2**CNT_W - 1 ||
        ALLRED_T  < 1 || ALLRED_T  > 2**CNT_W - 1 ||
        WALK_T    < 1 || WALK_T    > 2**CNT_W - 1) begin : g_bad_duration
        $error("semaforo_sched: every duration must lie in 1..2**CNT_W-1");
    end

    localparam logic [CNT_W-1:0] c_green_min_last = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] c_green_max_last = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] c_yellow_last    = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] c_allred_last    = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] c_walk_last      = CNT_W'(WALK_T - 1);
    localparam logic [CNT_W-1:0] c_timer_sat      = '1;

    phase_e           r_state;
    logic [CNT_W-1:0] r_timer;
    logic [2:0]       r_pend;
    logic [1:0]       r_last_served;
    light_t           r_ns_light;
    light_t           r_ew_light;
    logic             r_walk;
    logic             r_ped_ack;

    phase_e     w_next;
    logic [2:0] w_req;
    logic [2:0] w_own_active;
    logic [2:0] w_enter;
    logic [2:0] w_pend_next;
    logic [2:0] w_grant;
    logic       w_grant_valid;
    logic [1:0] w_grant_idx;
    logic       w_granting;

    assign w_req = {sig.req_ped, sig.req_ew, sig.req_ns};

    rr_arbiter3 u_arb (
        .pend        (r_pend),
        .last_served (r_last_served),
        .grant       (w_grant),
        .valid       (w_grant_valid)
    );

    assign w_grant_idx = w_grant[NS] ? NS : (w_grant[EW] ? EW : PED);

    always_comb begin
        w_next = r_state;
        if (sig.tick) begin
            case (r_state)
                ALL_RED: begin
                    if (sig.emerg)
                        w_next = EMERG;
                    else if (r_timer >= c_allred_last && w_grant_valid)
                        w_next = (w_grant_idx == NS) ? NS_GREEN :
                                 (w_grant_idx == EW) ? EW_GREEN : PED_WALK;
                end
                NS_GREEN: begin
                    if (sig.emerg || r_timer == c_green_max_last ||
                        (r_timer >= c_green_min_last && (r_pend[EW] || r_pend[PED])))
                        w_next = NS_YELLOW;
                end
                EW_GREEN: begin
                    if (sig.emerg || r_timer == c_green_max_last ||
                        (r_timer >= c_green_min_last && (r_pend[NS] || r_pend[PED])))
                        w_next = EW_YELLOW;
                end
                NS_YELLOW, EW_YELLOW: begin
                    if (r_timer == c_yellow_last)
                        w_next = sig.emerg ? EMERG : ALL_RED;
                end
                PED_WALK: begin
                    if (sig.emerg)
                        w_next = EMERG;
                    else if (r_timer == c_walk_last)
                        w_next = ALL_RED;
                end
                EMERG: begin
                    if (!sig.emerg)
                        w_next = ALL_RED;
                end
                default: w_next = ALL_RED;
            endcase
        end
    end

    // A requester's own service phase masks its sensor; entering that phase clears it.
    assign w_own_active = {r_state == PED_WALK, r_state == EW_GREEN, r_state == NS_GREEN};
    assign w_enter      = {w_next == PED_WALK && r_state != PED_WALK,
                           w_next == EW_GREEN && r_state != EW_GREEN,
                           w_next == NS_GREEN && r_state != NS_GREEN};
    assign w_pend_next  = (r_pend | (w_req & ~w_own_active)) & ~w_enter;
    assign w_granting   = (r_state == ALL_RED) && (|w_enter);

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            r_state       <= ALL_RED;
            r_timer       <= '0;
            r_pend        <= 3'b000;
            r_last_served <= PED;
            r_ns_light    <= LIGHT_R;
            r_ew_light    <= LIGHT_R;
            r_walk        <= 1'b0;
            r_ped_ack     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (sig.tick) begin
                if (w_next != r_state)
                    r_timer <= '0;
                else if (r_timer != c_timer_sat)
                    r_timer <= r_timer + 1'b1;
            end
            r_pend <= w_pend_next;
            if (w_granting)
                r_last_served <= w_grant_idx;
            r_ns_light <= ns_light_of(w_next);
            r_ew_light <= ew_light_of(w_next);
            r_walk     <= (w_next == PED_WALK);
            r_ped_ack  <= w_enter[PED];
        end
    end

    assign sig.ns_light = r_ns_light;
    assign sig.ew_light = r_ew_light;
    assign sig.walk     = r_walk;
    assign sig.ped_ack  = r_ped_ack;
    assign sig.phase    = r_state;

endmodule
`default_nettype wire
